// File: rtl/mldsa_pkg.sv
// ML-DSA shared constants, types and encoding offsets.
// Used by power2round_stage, power2round_core and the t0 packer.
package mldsa_pkg;

  localparam int N      = 256;
  localparam int COEF_W = 23;
  localparam int D      = 13;
  localparam int T1_W   = 10;
  localparam int ADDR_W = 8;

  localparam int unsigned Q = 8380417;

  // t0 is stored as 2^(D-1) - t0 so the packer sees an unsigned value
  localparam logic [D-1:0] T0_OFFSET = 13'd4096;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } p2r_state_e;

  typedef struct packed {
    logic [T1_W-1:0] t1;
    logic [D-1:0]    t0_enc;
  } p2r_res_t;

endpackage

// File: rtl/power2round_core.sv
// Power2Round split (d=13), purely combinational.
// Ports: r (coefficient) in; res {t1, t0_enc = 4096 - t0 mod 2^13} out.
module power2round_core
  import mldsa_pkg::*;
(
  input  logic [COEF_W-1:0] r,
  output p2r_res_t          res
);

  localparam logic [COEF_W:0] RND =
    (COEF_W+1)'(T0_OFFSET) - (COEF_W+1)'(1);

  logic [T1_W-1:0] t1;

  always_comb begin
    t1 = T1_W'(({1'b0, r} + RND) >> D);
    res.t1 = t1;
    // low D bits of t1<<13 are zero, so this is 4096 - t0 mod 2^13
    res.t0_enc = D'({1'b0, t1, {D{1'b0}}}
               + (COEF_W+1)'(T0_OFFSET)
               - {1'b0, r});
  end

endmodule

// File: rtl/power2round_stage.sv
// Streams N t coefficients from RAM, writes t1 and encoded t0.
// Ports: clk, reset (async high), start, in_data/in_en/in_addr (RAM),
//   t0_out/t0_en/t0_addr, t1_out/t1_en/t1_addr, busy, done.
//   With POWER2ROUND_RANGE_CHECK_EN: range_err (sticky r >= Q flag).
module power2round_stage
  import mldsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COEF_W-1:0] in_data,
  output logic              in_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [D-1:0]      t0_out,
  output logic              t0_en,
  output logic [ADDR_W-1:0] t0_addr,
  output logic [T1_W-1:0]   t1_out,
  output logic              t1_en,
  output logic [ADDR_W-1:0] t1_addr,
  output logic              busy,
  output logic              done
`ifdef POWER2ROUND_RANGE_CHECK_EN
  ,
  output logic              range_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  p2r_state_e        state, state_nx;
  logic [ADDR_W-1:0] rd_cnt;
  logic              v1;
  logic [ADDR_W-1:0] a1;
  logic              last_beat;
  p2r_res_t          res;

  assign last_beat = t0_en && (t0_addr == LAST);
  assign in_addr   = rd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = READ;
      READ:  if (rd_cnt == LAST) state_nx = DRAIN;
      DRAIN: if (last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_en = 1'b0;
    busy  = 1'b1;
    unique case (state)
      IDLE:    busy  = 1'b0;
      READ:    in_en = 1'b1;
      DRAIN:   in_en = 1'b0;
      default: busy  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
    end else if (state == IDLE && start) begin
      rd_cnt <= '0;
    end else if (state == READ) begin
      rd_cnt <= rd_cnt + ADDR_W'(1);
    end
  end

  // in_data is the RAM's registered output; track which beat it is
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      a1 <= '0;
    end else begin
      v1 <= in_en;
      a1 <= in_addr;
    end
  end

  power2round_core u_core (
    .r   (in_data),
    .res (res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t0_out  <= '0;
      t1_out  <= '0;
      t0_en   <= 1'b0;
      t1_en   <= 1'b0;
      t0_addr <= '0;
      t1_addr <= '0;
    end else begin
      t0_en   <= v1;
      t1_en   <= v1;
      t0_addr <= a1;
      t1_addr <= a1;
      if (v1) begin
        t0_out <= res.t0_enc;
        t1_out <= res.t1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == DRAIN) && last_beat;
  end

`ifdef POWER2ROUND_RANGE_CHECK_EN
  localparam logic [COEF_W-1:0] QV = COEF_W'(Q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_err <= 1'b0;
    end else if (state == IDLE && start) begin
      range_err <= 1'b0;
    end else if (v1 && in_data >= QV) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule
